// File: rtl/dnn_pkg.sv
// Types, state encoding and requantisation shared by the dense and conv layers.
package dnn_pkg;

  localparam int DNN_ACC_W = 32;
  localparam int N_CLASSES = 10;

  typedef logic signed [7:0]           act_t;
  typedef logic signed [DNN_ACC_W-1:0] acc_t;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_MAC,
    ST_DRAIN,
    ST_EMIT,
    ST_DONE
  } fc_state_t;

  // Round-half-up, arithmetic shift, optional ReLU, then clamp to int8.
  function automatic act_t requant_sat(acc_t acc, int shift, bit relu);
    acc_t r;
    r = acc;
    if (shift > 0) r = r + (acc_t'(1) <<< (shift - 1));
    r = r >>> shift;
    if (relu && r < 0) r = '0;
    if (r > acc_t'(127)) return act_t'(127);
    if (r < acc_t'(-128)) return act_t'(-128);
    return act_t'(r);
  endfunction

endpackage

// File: rtl/fc_weight_rom.sv
// Neuron-major int8 weight ROM with one cycle of read latency.
module fc_weight_rom
  import dnn_pkg::*;
#(
  parameter int N_IN  = 84,
  parameter int N_OUT = 10,
  parameter int AW    = $clog2(N_OUT * N_IN),
  parameter logic [N_OUT*N_IN*8-1:0] WEIGHTS = '0
) (
  input  logic              clk,
  input  logic [AW-1:0]     addr,
  output logic signed [7:0] data
);

  always_ff @(posedge clk) begin
    data <= act_t'(WEIGHTS[{addr, 3'b000} +: 8]);
  end

endmodule

// File: rtl/fc_logits_layer.sv
// Final dense layer: buffers one int8 frame, runs N_OUT dot products + bias,
// and streams requantised int8 logits followed by a single done pulse.
//   state | meaning
//   LOAD  | accept activations into the frame buffer
//   MAC   | N_IN multiply-accumulate issues for the current neuron
//   DRAIN | two cycles flushing the ROM/product pipeline
//   EMIT  | logit on data_out, advance neuron
//   DONE  | layer_done_out pulse, back to LOAD
module fc_logits_layer
  import dnn_pkg::*;
#(
  parameter int N_IN  = 84,
  parameter int N_OUT = 10,
  parameter int ACC_W = DNN_ACC_W,
  parameter int SHIFT = 7,
  parameter int RELU  = 0,
  parameter logic [N_OUT*N_IN*8-1:0]  WEIGHTS = '0,
  parameter logic [N_OUT*ACC_W-1:0]   BIASES  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic signed [7:0] act_in,
  input  logic              act_valid_in,
  output logic              act_ready_out,
  output logic signed [7:0] data_out,
  output logic              data_valid_out,
  output logic              layer_done_out,
  output logic              busy
);

  localparam int CW = $clog2(N_IN);
  localparam int NW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int AW = $clog2(N_OUT * N_IN);
  localparam int BW = $clog2(N_OUT * ACC_W);
  localparam logic [CW-1:0] IN_LAST     = CW'(N_IN - 1);
  localparam logic [NW-1:0] NEURON_LAST = NW'(N_OUT - 1);

  fc_state_t state, state_next;
  logic [CW-1:0] in_cnt, mac_cnt;
  logic [NW-1:0] neuron;
  act_t act_buf [N_IN];
  act_t act_q, w_q;
  logic rd_v, prod_v;
  logic signed [15:0] prod;
  logic signed [ACC_W-1:0] acc, acc_sum, bias_val;
  logic [AW-1:0] w_addr;
  logic xfer, emit_next;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_LOAD;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_LOAD:  if (xfer && in_cnt == IN_LAST) state_next = ST_MAC;
      ST_MAC:   if (mac_cnt == IN_LAST) state_next = ST_DRAIN;
      ST_DRAIN: if (mac_cnt == CW'(1)) state_next = ST_EMIT;
      ST_EMIT:  state_next = (neuron == NEURON_LAST) ? ST_DONE : ST_MAC;
      ST_DONE:  state_next = ST_LOAD;
      default:  state_next = ST_LOAD;
    endcase
  end

  always_comb begin
    act_ready_out  = (state == ST_LOAD);
    layer_done_out = (state == ST_DONE);
  end

  assign xfer      = act_valid_in && act_ready_out;
  assign emit_next = (state == ST_DRAIN) && (mac_cnt == CW'(1));
  assign w_addr    = AW'(neuron) * AW'(N_IN) + AW'(mac_cnt);
  assign bias_val  = BIASES[BW'(neuron) * BW'(ACC_W) +: ACC_W];
  assign acc_sum   = prod_v ? acc + ACC_W'(prod) : acc;

  fc_weight_rom #(
    .N_IN    (N_IN),
    .N_OUT   (N_OUT),
    .WEIGHTS (WEIGHTS)
  ) u_rom (
    .clk  (clk),
    .addr (w_addr),
    .data (w_q)
  );

  always_ff @(posedge clk) begin
    if (xfer) act_buf[in_cnt] <= act_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_cnt         <= '0;
      mac_cnt        <= '0;
      neuron         <= '0;
      busy           <= 1'b0;
      rd_v           <= 1'b0;
      prod_v         <= 1'b0;
      act_q          <= '0;
      prod           <= '0;
      acc            <= '0;
      data_out       <= '0;
      data_valid_out <= 1'b0;
    end else begin
      if (xfer) begin
        in_cnt <= (in_cnt == IN_LAST) ? '0 : in_cnt + 1'b1;
        busy   <= 1'b1;
      end
      if (state == ST_DONE) begin
        in_cnt <= '0;
        neuron <= '0;
        busy   <= 1'b0;
      end
      if (state == ST_MAC || state == ST_DRAIN)
        mac_cnt <= (state_next != state) ? '0 : mac_cnt + 1'b1;
      if (state == ST_EMIT && neuron != NEURON_LAST)
        neuron <= neuron + 1'b1;
      // act_q is read alongside the ROM so both operands line up one cycle later
      rd_v   <= (state == ST_MAC);
      act_q  <= act_buf[mac_cnt];
      prod_v <= rd_v;
      prod   <= 16'(act_q) * 16'(w_q);
      acc    <= (state == ST_MAC && mac_cnt == '0) ? bias_val : acc_sum;
      // The last product is folded in here so the logit is visible during EMIT
      data_valid_out <= emit_next;
      if (emit_next) data_out <= requant_sat(acc_t'(acc_sum), SHIFT, RELU != 0);
    end
  end

endmodule

// File: doc/fc_logits_layer.md
Name: fc_logits_layer

Overview:
- Final fully-connected (dense) layer of the classifier.
- Buffers one frame of N_IN int8 activations from the preceding hidden layer, then computes N_OUT int32 dot products plus bias.
- Requantises each result to int8 and streams the N_OUT logits, one per valid beat, into the argmax/prediction stage, followed by a single-cycle layer-done pulse.
- Sits directly upstream of the prediction (argmax) block and drives its data/valid/done inputs.

Parameters:
- N_IN, 84, activations per frame (input vector length).
- N_OUT, 10, output neurons (class logits).
- ACC_W, 32, signed accumulator width.
- SHIFT, 7, requantisation right-shift (0 = no shift, no rounding).
- RELU, 0, 1 = clamp negative outputs to 0 before saturation; 0 for the logits layer.
- WEIGHT_FILE, "fc3_w.mem", hex init file, N_OUT*N_IN int8, neuron-major.
- BIAS_FILE, "fc3_b.mem", hex init file, N_OUT int32, already in the accumulator scale.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: rst, synchronous, active-high; clock clk.
- act_in  in  8  signed activation.
- act_valid_in  in  1  act_in valid.
- act_ready_out  out  1  block accepts act_in this cycle.
- data_out  out  8  signed requantised logit.
- data_valid_out  out  1  data_out valid, one pulse per neuron.
- layer_done_out  out  1  one-cycle pulse after the last logit of a frame.
- busy  out  1  high from first accepted activation until layer_done_out.

Behaviour:
- Reset: state LOAD, in_cnt=0, neuron=0, act_ready_out=1, data_out=0, data_valid_out=0, layer_done_out=0, busy=0. Activation buffer contents are don't-care.
- FSM states: LOAD, MAC, DRAIN, EMIT, DONE.
- LOAD:
  - Transfer occurs when act_valid_in && act_ready_out; act_in is written to buf[in_cnt] and in_cnt increments.
  - busy rises on the first transfer.
  - Gaps in act_valid_in are allowed and cause no state change.
  - The transfer with in_cnt==N_IN-1 moves the FSM to MAC. act_ready_out drops the next cycle and stays low until back in LOAD.
- MAC (N_IN cycles per neuron):
  - Issue weight address neuron*N_IN+k and buf index k, for k=0..N_IN-1.
  - ROM read latency is 1 cycle. The product is registered as signed 8x8 -> 16 bit, then sign-extended and accumulated.
  - The accumulator is loaded with bias[neuron] at the start of each neuron.
- DRAIN: 2 cycles while the pipeline flushes the last product into the accumulator.
- EMIT (1 cycle):
  - Add 1<<(SHIFT-1) if SHIFT>0.
  - Arithmetic shift right by SHIFT.
  - If RELU, clamp negative values to 0.
  - Saturate to [-128, 127].
  - Register the result to data_out with data_valid_out=1 for exactly this cycle.
  - If neuron<N_OUT-1: neuron++ and go to MAC. Otherwise go to DONE.
- Per-neuron period is exactly N_IN+3 cycles. Logit j has data_valid_out high (N_IN+3)*(j+1) cycles after the cycle of the final activation transfer, for j=0..N_OUT-1.
- DONE:
  - layer_done_out=1 for one cycle, exactly one cycle after the last data_valid_out. It must never coincide with a data_valid_out, because the argmax stage needs the final logit registered before done.
  - busy=0, in_cnt=0, neuron=0, go to LOAD; act_ready_out=1 the following cycle.
- Output hold: data_out holds its last value when not valid. data_valid_out and layer_done_out are 0 outside their pulse cycles.
- Accumulator overflow is not handled; ACC_W must hold N_IN*2^14 plus the bias range. Wrap beyond that is a parameterisation error.
- rst mid-frame, in any state: return to the reset values above on the next edge. No partial logits and no done pulse are emitted, and the partial frame is discarded.
- Back-to-back frames: a new frame is accepted only after DONE; there is no overlap of load and compute.

Decomposition:
- Shared package dnn_pkg holds:
  - act_t (logic signed [7:0]) and acc_t (logic signed [ACC_W-1:0]);
  - N_CLASSES=10;
  - state enum fc_state_t;
  - function requant_sat(acc, shift, relu) returning act_t, reused by the other dense and conv layers.
- One sub-module, fc_weight_rom: synchronous-read ROM of N_OUT*N_IN int8 initialised from WEIGHT_FILE, 1-cycle latency.
- Bias ROM, activation buffer and FSM live in the top.

Test Plan:
- Zero activations, all-zero weights, bias[j]=j<<7, SHIFT=7: send 84 beats. Expect data_out=0..9 on 10 pulses spaced 87 cycles apart, the first 87 cycles after the last beat. layer_done_out one cycle after the 10th pulse. Argmax stage reports 9.
- act=1 everywhere, weights neuron j all =(j==3)?2:0, bias 0, SHIFT=0: logit 3 = 168 saturates to 127, all others 0. Check the negative saturation case with weights -2: logit -168 -> -128.
- Rounding with SHIFT=7: accumulator 64 -> 1, 63 -> 0, -64 -> 0, -65 -> -1. RELU=1 maps -65 to 0.
- Drive act_valid_in with random gaps (about 50% duty): results identical to gap-free run. act_ready_out low from the cycle after the 84th beat until one cycle after layer_done_out; no beat is accepted while low.
- Assert rst during MAC of neuron 5: no further data_valid_out or layer_done_out. A following full frame produces the correct 10 logits.
- Two consecutive frames with different vectors: two done pulses, correct logits each, busy low for exactly the one cycle between frames when input is presented continuously.
